// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control FSM:
// state enum, opcode constants, immediate-format, ALU-operation and
// datapath-select codes, plus the bundled control-word struct.
package rv_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST      = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_MEMADR   = 5'd3,
    S_MEMREAD  = 5'd4,
    S_MEMWB    = 5'd5,
    S_MEMWRITE = 5'd6,
    S_EXECR    = 5'd7,
    S_EXECI    = 5'd8,
    S_ALUWB    = 5'd9,
    S_BRANCH   = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_JALR2    = 5'd13,
    S_JLINK    = 5'd14,
    S_LUI      = 5'd15,
    S_AUIPC    = 5'd16,
    S_ILLEGAL  = 5'd17
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_RTYPE = 7'h33;
  localparam logic [6:0] OP_ITYPE = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_SH = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // One state's worth of control strobes; aluop is resolved to alucontrol
  // by alu_decoder.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] immsrc;
    logic [1:0] aluop;
    logic       retire;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
//  aluop     in  2  00=add, 01=sub, 10=decode from funct3/funct7b5
//  funct3    in  3  instr[14:12]
//  funct7b5  in  1  instr[30]
//  op5       in  1  instr[5]; 1 for R-type, so addi never becomes sub
//  alucontrol out 4 ALU operation code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          // srai/sra share funct7b5 with R-type, so op5 is not consulted here
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the RV32I multicycle core.
//  Inputs : clk, rst_n (async active-low), op/funct3/funct7b5 from IR,
//           zero (ALU flag), mem_ready (memory handshake completion).
//  Outputs: mem_req/memwrite/adrsrc (memory), irwrite/pcwrite/regwrite
//           (register enables), alusrca/alusrcb/resultsrc/immsrc/alucontrol
//           (datapath selects), retire (last cycle of instruction),
//           illegal (held while parked in the illegal state).
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       retire,
  output logic       illegal
);

  localparam state_t RESET_STATE = RESET_STATE_IDLE ? S_RST : S_FETCH;

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl_s;
  logic [3:0] alucontrol_s;

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          // only beq/bne are implemented
          OP_BR:             state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_JLINK;
      S_JALR:     state_d = S_JALR2;
      S_JALR2:    state_d = S_JLINK;
      S_JLINK:    state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from state (plus handshake/zero where strobes must be qualified)
  always_comb begin
    ctrl_s = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_req   = 1'b1;
        // IR and PC+4 commit only on the completing cycle
        ctrl_s.irwrite   = mem_ready;
        ctrl_s.pcwrite   = mem_ready;
        ctrl_s.alusrca   = SRCA_PC;
        ctrl_s.alusrcb   = SRCB_FOUR;
        ctrl_s.resultsrc = RES_ALU;
      end
      S_DECODE: begin
        ctrl_s.alusrca = SRCA_OLDPC;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsrc  = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ctrl_s.alusrca = SRCA_RS1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.resultsrc = RES_MEM;
        ctrl_s.regwrite  = 1'b1;
        ctrl_s.retire    = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_s.mem_req  = 1'b1;
        ctrl_s.memwrite = 1'b1;
        ctrl_s.adrsrc   = 1'b1;
        ctrl_s.retire   = mem_ready;
      end
      S_EXECR: begin
        ctrl_s.alusrca = SRCA_RS1;
        ctrl_s.alusrcb = SRCB_RS2;
        ctrl_s.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_s.alusrca = SRCA_RS1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsrc  = (funct3[1:0] == 2'b01) ? IMM_SH : IMM_I;
        ctrl_s.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_s.resultsrc = RES_ALUOUT;
        ctrl_s.regwrite  = 1'b1;
        ctrl_s.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alusrca   = SRCA_RS1;
        ctrl_s.alusrcb   = SRCB_RS2;
        ctrl_s.aluop     = ALUOP_SUB;
        ctrl_s.resultsrc = RES_ALUOUT;
        // funct3[0] inverts the sense: beq takes on zero, bne on non-zero
        ctrl_s.pcwrite   = zero ^ funct3[0];
        ctrl_s.retire    = 1'b1;
      end
      S_JAL, S_JALR2: begin
        ctrl_s.resultsrc = RES_ALUOUT;
        ctrl_s.pcwrite   = 1'b1;
      end
      S_JALR: begin
        ctrl_s.alusrca = SRCA_RS1;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsrc  = IMM_I;
      end
      S_JLINK: begin
        ctrl_s.alusrca   = SRCA_OLDPC;
        ctrl_s.alusrcb   = SRCB_FOUR;
        ctrl_s.resultsrc = RES_ALU;
        ctrl_s.regwrite  = 1'b1;
        ctrl_s.retire    = 1'b1;
      end
      S_LUI, S_AUIPC: begin
        ctrl_s.alusrca = (state_q == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ctrl_s.alusrcb = SRCB_IMM;
        ctrl_s.immsrc  = IMM_U;
      end
      S_ILLEGAL: ctrl_s.illegal = 1'b1;
      default:   ctrl_s = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_s.aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol_s)
  );

  // Gating with rst_n drops mem_req at once when reset asserts mid-transaction
  always_comb begin
    if (rst_n) begin
      mem_req    = ctrl_s.mem_req;
      memwrite   = ctrl_s.memwrite;
      adrsrc     = ctrl_s.adrsrc;
      irwrite    = ctrl_s.irwrite;
      pcwrite    = ctrl_s.pcwrite;
      regwrite   = ctrl_s.regwrite;
      alusrca    = ctrl_s.alusrca;
      alusrcb    = ctrl_s.alusrcb;
      resultsrc  = ctrl_s.resultsrc;
      immsrc     = ctrl_s.immsrc;
      alucontrol = alucontrol_s;
      retire     = ctrl_s.retire;
      illegal    = ctrl_s.illegal;
    end else begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      resultsrc  = 2'b00;
      immsrc     = 3'b000;
      alucontrol = 4'b0000;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller. Each table row is
// one clock cycle: inputs are applied just after the rising edge and all
// outputs are compared, as one packed word, at the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'h00;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] immsrc;
  logic [3:0] alucontrol;
  logic       retire, illegal;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
    .alucontrol(alucontrol), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,memwrite,adrsrc,irwrite,pcwrite,regwrite,alusrca,alusrcb,resultsrc,immsrc,alucontrol,retire,illegal}
  logic [20:0] act;
  assign act = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, alusrca, alusrcb,
                resultsrc, immsrc, alucontrol, retire, illegal};

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[96];
  int   nv = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [20:0] pk(input logic mr, mw, ad, ir, pc, rw,
                                     input logic [1:0] a, b, res,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic ret, ill);
    return {mr, mw, ad, ir, pc, rw, a, b, res, imm, alu, ret, ill};
  endfunction

  task automatic add_v(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic r, input logic [20:0] e);
    vecs[nv].op = o; vecs[nv].f3 = f3; vecs[nv].f7 = f7;
    vecs[nv].z = z; vecs[nv].rdy = r; vecs[nv].exp = e;
    nv++;
  endtask

  task automatic check(input string name, input int id, input logic [20:0] e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, id, act, e);
    end
  endtask

  // One cycle: drive inputs (caller is at posedge+1), check at negedge, move to next posedge+1
  task automatic step(input string name, input int id, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input logic r, input logic [20:0] e);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = r;
    @(negedge clk);
    check(name, id, e);
    @(posedge clk);
    #1;
  endtask

  logic [20:0] e_zero, e_f1, e_f0, e_decb, e_decj, e_aluwb, e_jlink, e_ill, e_mread;

  initial begin
    e_zero  = 21'd0;
    e_f1    = pk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b10,3'b000,4'b0000,1'b0,1'b0);
    e_f0    = pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,3'b000,4'b0000,1'b0,1'b0);
    e_decb  = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b010,4'b0000,1'b0,1'b0);
    e_decj  = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b011,4'b0000,1'b0,1'b0);
    e_aluwb = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b1,1'b0);
    e_jlink = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b10,2'b10,3'b000,4'b0000,1'b1,1'b0);
    e_ill   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b1);
    e_mread = pk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b0);

    // reset-release cycle in S_RST
    add_v(7'h33, 3'b000, 1'b0, 1'b0, 1'b1, e_zero);
    // add x3,x1,x2: 4 cycles
    add_v(7'h33, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h33, 3'b000, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h33, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h33, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb);
    // sub
    add_v(7'h33, 3'b000, 1'b1, 1'b0, 1'b1, e_f1);
    add_v(7'h33, 3'b000, 1'b1, 1'b0, 1'b1, e_decb);
    add_v(7'h33, 3'b000, 1'b1, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b000,4'b0001,1'b0,1'b0));
    add_v(7'h33, 3'b000, 1'b1, 1'b0, 1'b1, e_aluwb);
    // lw with three wait cycles on the data read: 8 cycles
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, e_decb);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, e_mread);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, e_mread);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b0, e_mread);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b1, e_mread);
    add_v(7'h03, 3'b010, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b01,3'b000,4'b0000,1'b1,1'b0));
    // sw with one fetch wait and one write wait
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b0, e_f0);
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b001,4'b0000,1'b0,1'b0));
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b0, pk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h23, 3'b010, 1'b0, 1'b0, 1'b1, pk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b1,1'b0));
    // beq zero=1 (taken), bne zero=1 (not taken)
    add_v(7'h63, 3'b000, 1'b0, 1'b1, 1'b1, e_f1);
    add_v(7'h63, 3'b000, 1'b0, 1'b1, 1'b1, e_decb);
    add_v(7'h63, 3'b000, 1'b0, 1'b1, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b00,3'b000,4'b0001,1'b1,1'b0));
    add_v(7'h63, 3'b001, 1'b0, 1'b1, 1'b1, e_f1);
    add_v(7'h63, 3'b001, 1'b0, 1'b1, 1'b1, e_decb);
    add_v(7'h63, 3'b001, 1'b0, 1'b1, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b000,4'b0001,1'b1,1'b0));
    // srai: shamt immediate, sra
    add_v(7'h13, 3'b101, 1'b1, 1'b0, 1'b1, e_f1);
    add_v(7'h13, 3'b101, 1'b1, 1'b0, 1'b1, e_decb);
    add_v(7'h13, 3'b101, 1'b1, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b101,4'b1001,1'b0,1'b0));
    add_v(7'h13, 3'b101, 1'b1, 1'b0, 1'b1, e_aluwb);
    // slli: shamt immediate, sll
    add_v(7'h13, 3'b001, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h13, 3'b001, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h13, 3'b001, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b101,4'b0111,1'b0,1'b0));
    add_v(7'h13, 3'b001, 1'b0, 1'b0, 1'b1, e_aluwb);
    // addi with instr[30]=1 stays add
    add_v(7'h13, 3'b000, 1'b1, 1'b0, 1'b1, e_f1);
    add_v(7'h13, 3'b000, 1'b1, 1'b0, 1'b1, e_decb);
    add_v(7'h13, 3'b000, 1'b1, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h13, 3'b000, 1'b1, 1'b0, 1'b1, e_aluwb);
    // jal: 4 cycles
    add_v(7'h6F, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h6F, 3'b000, 1'b0, 1'b0, 1'b1, e_decj);
    add_v(7'h6F, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h6F, 3'b000, 1'b0, 1'b0, 1'b1, e_jlink);
    // jalr: 5 cycles
    add_v(7'h67, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h67, 3'b000, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h67, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h67, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,3'b000,4'b0000,1'b0,1'b0));
    add_v(7'h67, 3'b000, 1'b0, 1'b0, 1'b1, e_jlink);
    // lui / auipc
    add_v(7'h37, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h37, 3'b000, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h37, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b01,2'b00,3'b100,4'b0000,1'b0,1'b0));
    add_v(7'h37, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb);
    add_v(7'h17, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h17, 3'b000, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h17, 3'b000, 1'b0, 1'b0, 1'b1, pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b100,4'b0000,1'b0,1'b0));
    add_v(7'h17, 3'b000, 1'b0, 1'b0, 1'b1, e_aluwb);
    // unsupported opcode parks in ILLEGAL
    add_v(7'h7F, 3'b000, 1'b0, 1'b0, 1'b1, e_f1);
    add_v(7'h7F, 3'b000, 1'b0, 1'b0, 1'b1, e_decb);
    add_v(7'h7F, 3'b000, 1'b0, 1'b0, 1'b1, e_ill);

    // outputs held at zero while reset is asserted
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("in_reset", 0, e_zero);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      step("row", i, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].rdy, vecs[i].exp);
    end

    // ILLEGAL is terminal: held for 100 cycles with memory ready and other opcodes applied
    for (int i = 0; i < 100; i++) begin
      step("illegal_hold", i, 7'h33, 3'b000, 1'b0, 1'b1, 1'b1, e_ill);
    end

    // reset pulse while a fetch is waiting on memory
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 0, 7'h33, 3'b000, 1'b0, 1'b0, 1'b0, e_zero);
    op = 7'h33; mem_ready = 1'b0;
    @(negedge clk);
    check("fetch_wait", 0, e_f0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_abort", 0, e_zero);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("restart_rst", 0, 7'h33, 3'b000, 1'b0, 1'b0, 1'b1, e_zero);
    step("restart_fetch", 0, 7'h63, 3'b100, 1'b0, 1'b0, 1'b1, e_f1);
    // blt lies outside the beq/bne branch set: DECODE sends it to ILLEGAL
    step("blt_decode", 0, 7'h63, 3'b100, 1'b0, 1'b0, 1'b1, e_decb);
    step("blt_illegal", 0, 7'h63, 3'b100, 1'b0, 1'b0, 1'b1, e_ill);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
